// File: rtl/instr_decode_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_decode_stage_if : fetch-side and decode-side handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int OPC_W = 5,
  parameter int REG_W = 5,
  parameter int IMM_W = 16,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  localparam int INSTR_W = OPC_W + 2*REG_W + 1 + IMM_W;

  logic               flush;
  logic               sext_en;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_dest;
  logic [REG_W-1:0]   out_src1;
  logic [REG_W-1:0]   out_src2;
  logic               out_imm_flag;
  logic [XLEN-1:0]    out_imm;
  logic               out_illegal;
  logic [CNT_W-1:0]   dec_count;

  modport master (
    output flush, sext_en, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_dest, out_src1, out_src2,
           out_imm_flag, out_imm, out_illegal, dec_count
  );

  modport slave (
    input  flush, sext_en, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_dest, out_src1, out_src2,
           out_imm_flag, out_imm, out_illegal, dec_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_decode_stage : registered decode stage with a 2-entry skid buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int OPC_W   = 5,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int XLEN    = 32,
  parameter int NUM_OPS = 20,
  parameter int CNT_W   = 16
) (
  input  wire                  clk,
  input  wire                  rst,
  instr_decode_stage_if.slave  bus
);
  localparam int INSTR_W = OPC_W + 2*REG_W + 1 + IMM_W;
  localparam logic [OPC_W:0] c_num_ops = (OPC_W+1)'(NUM_OPS);

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             imm_flag;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } entry_t;

  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       w_accept;
  logic       w_handoff;
  entry_t     w_dec;
  logic [IMM_W-1:0] w_imm;

  // Decode happens on the incoming word so only finished entries are stored.
  always_comb begin
    w_imm          = bus.in_instr[IMM_W-1:0];
    w_dec.opcode   = bus.in_instr[INSTR_W-1 -: OPC_W];
    w_dec.dest     = bus.in_instr[INSTR_W-OPC_W-1 -: REG_W];
    w_dec.src1     = bus.in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    w_dec.imm_flag = bus.in_instr[IMM_W];
    w_dec.src2     = w_imm[IMM_W-1 -: REG_W];
    w_dec.imm      = bus.sext_en ? XLEN'($signed(w_imm)) : XLEN'(w_imm);
    w_dec.illegal  = ({1'b0, w_dec.opcode} >= c_num_ops);
  end

  assign w_accept  = bus.in_valid & ~skid_valid_q & ~bus.flush;
  assign w_handoff = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    cnt_d        = cnt_q + CNT_W'(w_handoff);
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_handoff) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        main_d = w_dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (main_valid_q) begin
        skid_d       = w_dec;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = w_dec;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready     = ~skid_valid_q;
  assign bus.out_valid    = main_valid_q;
  assign bus.out_opcode   = main_q.opcode;
  assign bus.out_dest     = main_q.dest;
  assign bus.out_src1     = main_q.src1;
  assign bus.out_src2     = main_q.src2;
  assign bus.out_imm_flag = main_q.imm_flag;
  assign bus.out_imm      = main_q.imm;
  assign bus.out_illegal  = main_q.illegal;
  assign bus.dec_count    = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_decode_stage : directed checks of decode, skid, flush and reset
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_decode_stage_if bus ();

  instr_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.sext_en  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b1;
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(bus.dec_count), 64'd0);
    chk("rst_opcode",    64'(bus.out_opcode), 64'd0);
    chk("rst_imm",       64'(bus.out_imm), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);

    // Basic decode, sign-extended
    bus.in_valid = 1'b1; bus.in_instr = 32'h1845FFFE; bus.sext_en = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid",  64'(bus.out_valid), 64'd1);
    chk("t1_opcode", 64'(bus.out_opcode), 64'd3);
    chk("t1_dest",   64'(bus.out_dest), 64'd1);
    chk("t1_src1",   64'(bus.out_src1), 64'd2);
    chk("t1_src2",   64'(bus.out_src2), 64'h1F);
    chk("t1_iflag",  64'(bus.out_imm_flag), 64'd1);
    chk("t1_imm",    64'(bus.out_imm), 64'hFFFFFFFE);
    chk("t1_illegal",64'(bus.out_illegal), 64'd0);
    step();
    chk("t1_drained", 64'(bus.out_valid), 64'd0);
    chk("t1_count",   64'(bus.dec_count), 64'd1);

    // Zero-extend
    bus.in_valid = 1'b1; bus.sext_en = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("t2_imm", 64'(bus.out_imm), 64'h0000FFFE);
    step();

    // All-zero word
    bus.in_valid = 1'b1; bus.in_instr = 32'h0; bus.sext_en = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t3_opcode", 64'(bus.out_opcode), 64'd0);
    chk("t3_iflag",  64'(bus.out_imm_flag), 64'd0);
    chk("t3_imm",    64'(bus.out_imm), 64'd0);
    step();

    // Illegal-opcode boundaries: 31, 19, 20
    bus.in_valid = 1'b1; bus.in_instr = 32'hF8000000;
    step();
    chk("t4_opcode",   64'(bus.out_opcode), 64'd31);
    chk("t4_illegal",  64'(bus.out_illegal), 64'd1);
    bus.in_instr = 32'h98000000;
    step();
    chk("t5_opcode",   64'(bus.out_opcode), 64'd19);
    chk("t5_illegal",  64'(bus.out_illegal), 64'd0);
    bus.in_instr = 32'hA0000000;
    step();
    bus.in_valid = 1'b0;
    chk("t6_opcode",   64'(bus.out_opcode), 64'd20);
    chk("t6_illegal",  64'(bus.out_illegal), 64'd1);
    step();
    chk("t6_count",    64'(bus.dec_count), 64'd6);

    // Stall: A to main, B to skid, C refused
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h08000001;
    step();
    chk("st_ready_a", 64'(bus.in_ready), 64'd1);
    bus.in_instr = 32'h10000002;
    step();
    bus.in_instr = 32'h18000003;
    step();
    chk("st_hold_op",  64'(bus.out_opcode), 64'd1);
    chk("st_hold_imm", 64'(bus.out_imm), 64'd1);
    chk("st_ready0",   64'(bus.in_ready), 64'd0);
    chk("st_count",    64'(bus.dec_count), 64'd6);
    bus.out_ready = 1'b1;
    step();
    chk("st_b_op",    64'(bus.out_opcode), 64'd2);
    chk("st_b_imm",   64'(bus.out_imm), 64'd2);
    chk("st_ready1",  64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("st_c_op",    64'(bus.out_opcode), 64'd3);
    chk("st_c_valid", 64'(bus.out_valid), 64'd1);
    step();
    chk("st_empty",   64'(bus.out_valid), 64'd0);
    chk("st_count3",  64'(bus.dec_count), 64'd9);

    // Flush with both entries full and an input presented
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h08000001;
    step();
    bus.in_instr = 32'h10000002;
    step();
    bus.in_instr = 32'h18000003; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_count", 64'(bus.dec_count), 64'd9);
    step();
    chk("fl_discard", 64'(bus.out_valid), 64'd0);

    // Flush coinciding with a handoff still counts
    bus.in_valid = 1'b1; bus.in_instr = 32'h08000001;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flh_valid", 64'(bus.out_valid), 64'd0);
    chk("flh_count", 64'(bus.dec_count), 64'd10);

    // Asynchronous reset in the middle of a stall
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h08000001;
    step();
    bus.in_instr = 32'h10000002;
    step();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",  64'(bus.out_valid), 64'd0);
    chk("ar_opcode", 64'(bus.out_opcode), 64'd0);
    chk("ar_imm",    64'(bus.out_imm), 64'd0);
    chk("ar_count",  64'(bus.dec_count), 64'd0);
    chk("ar_ready",  64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h1845FFFE; bus.sext_en = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("ar_new_valid",  64'(bus.out_valid), 64'd1);
    chk("ar_new_opcode", 64'(bus.out_opcode), 64'd3);
    chk("ar_new_imm",    64'(bus.out_imm), 64'hFFFFFFFE);
    step();
    chk("ar_new_count",  64'(bus.dec_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage. Sits between fetch and register-file read.
- Splits each instruction word into opcode, register and immediate fields, and extends the immediate to XLEN (sign- or zero-extended).
- Flags illegal opcodes.
- Uses a valid/ready handshake with a 2-entry skid buffer, so fetch stalls never create combinational ready paths.

Parameters:
- OPC_W, 5, opcode field width
- REG_W, 5, register-index field width
- IMM_W, 16, immediate field width; must be >= REG_W
- XLEN, 32, datapath width of extended immediate; must be >= IMM_W
- NUM_OPS, 20, count of legal opcodes; opcode >= NUM_OPS is illegal
- CNT_W, 16, width of accepted-instruction counter
- INSTR_W (localparam) = OPC_W + 2*REG_W + 1 + IMM_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- sext_en  in  1  1 = sign-extend immediate, 0 = zero-extend; sampled with the instruction on accept
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  INSTR_W  instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts
- out_opcode  out  OPC_W  opcode
- out_dest  out  REG_W  destination register
- out_src1  out  REG_W  source 1 register
- out_src2  out  REG_W  source 2 register
- out_imm_flag  out  1  immediate form
- out_imm  out  XLEN  extended immediate
- out_illegal  out  1  opcode >= NUM_OPS
- dec_count  out  CNT_W  instructions handed downstream

Behaviour:
- Field layout, MSB first:
  - opcode [INSTR_W-1 -: OPC_W]
  - dest [next REG_W]
  - src1 [next REG_W]
  - imm_flag [1 bit]
  - imm [IMM_W-1:0]
  - src2 = imm[IMM_W-1 -: REG_W]; it aliases the top of the immediate and is always output regardless of imm_flag.
- Extension: out_imm = {XLEN-IMM_W copies of (sext_en & imm[IMM_W-1]), imm}.
- Decode is performed at input accept and the result is stored. Stored entry = all decoded fields + illegal bit.
- Storage: main entry (drives outputs) plus skid entry.
  - in_ready = !skid_valid. It is a registered state bit; there is no combinational path from out_ready.
  - Input accept = in_valid & in_ready. Output handoff = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when main is empty or being handed off the same cycle.
- Transitions (main_valid, skid_valid):
  - (0,0): accept -> main.
  - (1,0): accept and no handoff -> skid. Accept and handoff -> main reloads. Handoff only -> (0,0).
  - (1,1): in_ready = 0. Handoff -> skid moves to main, skid empties.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- Stall hold: while out_valid & !out_ready, all out_* are held stable.
- dec_count increments by 1 on each output handoff. It wraps modulo 2^CNT_W and is not cleared by flush.
- Flush (synchronous, priority over everything):
  - Clears main_valid and skid_valid.
  - An input presented that cycle is discarded.
  - A handoff occurring in the same cycle still counts (downstream consumed it).
- Reset: out_valid = 0, in_ready = 1 after reset release (0 while rst asserted is not required; in_ready = !skid_valid = 1). All out_* data fields = 0, dec_count = 0.
- Reset mid-transfer discards both entries immediately (asynchronous).
- out_illegal instructions pass through normally; no trap handling in this block.

Test Plan:
- Default params, sext_en=1, in_instr=0x1845FFFE, out_ready=1 -> next cycle out_valid=1, opcode=3, dest=1, src1=2, imm_flag=1, src2=0x1F, out_imm=0xFFFFFFFE, illegal=0, dec_count=1.
- Same word with sext_en=0 -> out_imm=0x0000FFFE. Word 0x00000000 -> all fields 0, imm_flag=0.
- in_instr=0xF8000000 -> opcode=31, out_illegal=1. Opcode 19 -> illegal=0. Opcode 20 -> illegal=1.
- Stall: out_ready=0, stream 3 instructions back-to-back -> A held on outputs, B captured in skid, in_ready=0 on cycle 3. Raise out_ready -> A, B, C emerge in order, dec_count=3.
- Flush with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, dec_count unchanged. Flush together with a handoff -> dec_count +1.
- Assert rst mid-stall -> out_valid=0 immediately, all fields 0, dec_count=0. After release, a new instruction decodes with 1-cycle latency.
